// File: rtl/uart_word_rx_ctrl_pkg.sv
// Shared types and constants for the UART word receiver.
// Holds the receive FSM state type, frame geometry and the default bit period.
package uart_pkg;

   localparam int DATA_BITS            = 8;
   localparam int BYTES_PER_WORD       = 4;
   localparam int CLKS_PER_BIT_DEFAULT = 868;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_e;

endpackage

// File: rtl/uart_word_rx_ctrl_bit_timer.sv
// Loadable down counter used to pace UART bit sampling.
// done pulses for exactly one cycle when a loaded count runs out.
module bit_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_val,
   output logic        done
);

   logic [31:0] count_q, count_d;
   logic        armed_q, armed_d;

   // armed keeps done from repeating while the counter rests at zero
   always_comb begin
      count_d = count_q;
      armed_d = armed_q;
      if (load) begin
         count_d = load_val;
         armed_d = 1'b1;
      end else if (armed_q) begin
         if (count_q == 32'd0) begin
            armed_d = 1'b0;
         end else begin
            count_d = count_q - 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= 32'd0;
         armed_q <= 1'b0;
      end else begin
         count_q <= count_d;
         armed_q <= armed_d;
      end
   end

   assign done = armed_q && (count_q == 32'd0);

endmodule

// File: rtl/uart_word_rx_ctrl.sv
// UART receiver that packs four 8N1 bytes (byte 0 in the low lane) into a word,
// with frame-error detection and an inter-byte timeout that drops partial words.
module uart_word_rx_ctrl
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   output logic [31:0] word_data,
   output logic        word_valid,
   output logic        frame_err,
   output logic        timeout,
   output logic        busy
);

   localparam logic [31:0] HALF_LOAD  = 32'(CLKS_PER_BIT / 2 - 1);
   localparam logic [31:0] BIT_LOAD   = 32'(CLKS_PER_BIT - 1);
   localparam logic [31:0] IDLE_LIMIT = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
   localparam logic [2:0]  LAST_BIT   = 3'(DATA_BITS - 1);
   localparam logic [1:0]  LAST_LANE  = 2'(BYTES_PER_WORD - 1);

   rx_state_e              state_q, state_d;
   logic                   rx_meta_q, rx_s_q;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [1:0]             byte_idx_q, byte_idx_d;
   logic [23:0]            word_buf_q, word_buf_d;
   logic [31:0]            idle_cnt_q, idle_cnt_d;
   logic [31:0]            word_data_q, word_data_d;
   logic                   word_valid_q, word_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   timeout_q, timeout_d;
   logic                   timer_load;
   logic [31:0]            timer_val;
   logic                   timer_done;

   bit_timer u_bit_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Timeout is evaluated before the start check so a simultaneous start
   // edge still begins a fresh word at lane 0.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      byte_idx_d   = byte_idx_q;
      word_buf_d   = word_buf_q;
      idle_cnt_d   = idle_cnt_q;
      word_data_d  = word_data_q;
      word_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      timeout_d    = 1'b0;
      timer_load   = 1'b0;
      timer_val    = BIT_LOAD;

      case (state_q)
         IDLE: begin
            if (byte_idx_q != 2'd0) begin
               if (idle_cnt_q == IDLE_LIMIT) begin
                  timeout_d  = 1'b1;
                  byte_idx_d = 2'd0;
                  idle_cnt_d = 32'd0;
               end else begin
                  idle_cnt_d = idle_cnt_q + 32'd1;
               end
            end
            if (!rx_s_q) begin
               state_d    = START;
               timer_load = 1'b1;
               timer_val  = HALF_LOAD;
               idle_cnt_d = 32'd0;
            end
         end
         START: begin
            if (timer_done) begin
               if (rx_s_q) begin
                  state_d = IDLE;
               end else begin
                  state_d    = DATA;
                  timer_load = 1'b1;
                  bit_cnt_d  = 3'd0;
               end
            end
         end
         DATA: begin
            if (timer_done) begin
               shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
               timer_load = 1'b1;
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (timer_done) begin
               if (rx_s_q) begin
                  case (byte_idx_q)
                     2'd0:    word_buf_d[7:0]   = shift_q;
                     2'd1:    word_buf_d[15:8]  = shift_q;
                     2'd2:    word_buf_d[23:16] = shift_q;
                     default: ;
                  endcase
                  if (byte_idx_q == LAST_LANE) begin
                     word_data_d  = {shift_q, word_buf_q};
                     word_valid_d = 1'b1;
                  end
                  byte_idx_d = byte_idx_q + 2'd1;
                  state_d    = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  byte_idx_d  = 2'd0;
                  state_d     = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (rx_s_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= 3'd0;
         shift_q      <= '0;
         byte_idx_q   <= 2'd0;
         word_buf_q   <= 24'd0;
         idle_cnt_q   <= 32'd0;
         word_data_q  <= 32'd0;
         word_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         byte_idx_q   <= byte_idx_d;
         word_buf_q   <= word_buf_d;
         idle_cnt_q   <= idle_cnt_d;
         word_data_q  <= word_data_d;
         word_valid_q <= word_valid_d;
         frame_err_q  <= frame_err_d;
         timeout_q    <= timeout_d;
      end
   end

   assign word_data  = word_data_q;
   assign word_valid = word_valid_q;
   assign frame_err  = frame_err_q;
   assign timeout    = timeout_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: doc/uart_word_rx_ctrl.md
UART_WORD_RX_CTRL -- requirements
Module: uart_word_rx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868: clk cycles per UART bit (100 MHz / 115200); SHALL be >= 4.
REQ-002 Parameter TIMEOUT_BITS, default 20: max inter-byte idle gap, in bit periods, before a partial word is discarded.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 rx  in  1  serial line, idle high, asynchronous to clk.
REQ-006 word_data  out  32  last completed word; byte 0 received -> bits [7:0].
REQ-007 word_valid  out  1  one-cycle pulse; word_data is new this cycle.
REQ-008 frame_err  out  1  one-cycle pulse; stop bit sampled low.
REQ-009 timeout  out  1  one-cycle pulse; partial word discarded by timeout.
REQ-010 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; flops reset to 1.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: rx_s == 0 -> START; the bit timer loads CLKS_PER_BIT/2 - 1.
REQ-014 START: on timer expiry, rx_s == 1 -> IDLE (false start, no output pulse); rx_s == 0 -> DATA, timer loads CLKS_PER_BIT - 1.
REQ-015 DATA: each expiry samples rx_s LSB-first into the byte shifter and reloads CLKS_PER_BIT - 1; after the 8th sample -> STOP.
REQ-016 STOP: on expiry, rx_s == 1 -> byte accepted into lane byte_idx, byte_idx increments, -> IDLE; rx_s == 0 -> frame_err pulse, byte discarded, byte_idx cleared, -> WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rx_s == 1, then -> IDLE; a line held low SHALL NOT retrigger START.
REQ-018 Samples SHALL fall at bit centre: stop sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after START entry.
REQ-019 When the 4th byte is accepted, word_data SHALL update and word_valid SHALL pulse in the cycle after the stop sample; byte_idx wraps to 0.
REQ-020 word_data SHALL hold its value until the next completed word; partial words SHALL never appear on word_data.
REQ-021 A start edge arriving in the same cycle as IDLE entry from STOP SHALL be accepted (back-to-back bytes, zero idle time).
REQ-022 Idle counter: counts cycles in IDLE while byte_idx != 0; clears on leaving IDLE; at TIMEOUT_BITS*CLKS_PER_BIT -> byte_idx = 0, timeout pulse, counter clears.
REQ-023 If timeout and a start edge occur in the same cycle, timeout SHALL take effect and the new byte SHALL become byte 0.
REQ-024 Timer and idle counter SHALL be 32 bits wide and SHALL never wrap during normal operation.

Reset
REQ-025 reset low SHALL immediately force: FSM IDLE, byte_idx 0, counters 0, word_data 0, word_valid 0, frame_err 0, timeout 0, busy 0.
REQ-026 Reset asserted mid-frame SHALL discard all partial data; the first start bit after release begins byte 0.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS = 8, BYTES_PER_WORD = 4, and the default CLKS_PER_BIT.
REQ-028 Bit timing SHALL be a sub-module bit_timer: a loadable down counter with load, load value, and a one-cycle done output.

Verification (CLKS_PER_BIT = 16, TIMEOUT_BITS = 20)
REQ-029 Send 0x78, 0x56, 0x34, 0x12 -> one word_valid pulse, word_data = 0x12345678, frame_err and timeout stay 0.
REQ-030 Pulse rx low for 4 cycles -> false start, busy returns 0, no output pulses; next word is received correctly.
REQ-031 Send a byte with stop = 0, then 0xEF, 0xBE, 0xAD, 0xDE -> frame_err pulses once, then word_data = 0xDEADBEEF.
REQ-032 Send 2 bytes, then idle for 330 cycles -> timeout pulses at 320 idle cycles; the next 4 bytes form a fresh, correct word.
REQ-033 Assert reset during DATA of byte 3 -> all outputs 0 at once; after release, 4 bytes yield the correct word.
REQ-034 Send two words back-to-back with zero gap between stop and start -> two word_valid pulses with correct data.
